// File: rtl/game_pkg.sv
// Shared types and constants for the pass/bonus game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_EFF = 2'd1,
    EVAL     = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int SCORE_MAX = 100;
  localparam int HARD_FOLD = 28;
  // Feedback taps at bits 7,5,4,3 of the left-shifting Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [6:0] clamp_score(input logic [6:0] v);
    return (v > 7'(SCORE_MAX)) ? 7'(SCORE_MAX) : v;
  endfunction

  // Raw values 101..127 fold down to 73..99 so difficulty stays in 0..100.
  function automatic logic [6:0] fold_hard(input logic [6:0] v);
    return (v > 7'(SCORE_MAX)) ? v - 7'(HARD_FOLD) : v;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Effort handshake and stage-evaluator bus between the sequencer and its environment.
interface game_sequencer_if;
  logic       eff_valid;
  logic [6:0] eff_data;
  logic       eff_ready;
  logic [6:0] stg_work;
  logic [6:0] stg_hard;
  logic [1:0] stg_luck;
  logic       stg_pass_in;
  logic [1:0] stg_bonus_in;
  logic       stg_pass_out;
  logic [1:0] stg_bonus_out;

  modport master (
    input  eff_valid, eff_data, stg_pass_out, stg_bonus_out,
    output eff_ready, stg_work, stg_hard, stg_luck, stg_pass_in, stg_bonus_in
  );

  modport slave (
    output eff_valid, eff_data, stg_pass_out, stg_bonus_out,
    input  eff_ready, stg_work, stg_hard, stg_luck, stg_pass_in, stg_bonus_in
  );
endinterface

// File: rtl/game_lfsr.sv
// 8-bit Fibonacci LFSR producing per-round difficulty and luck values.
module game_lfsr
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [6:0] hard,
  output logic [1:0] luck
);

  logic [7:0] lfsr;

  // An all-zero state would lock up, so a zero seed loads 8'h01 instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'h01;
    end else if (load) begin
      lfsr <= (seed == 8'h00) ? 8'h01 : seed;
    end else if (step) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign hard = fold_hard(lfsr[6:0]);
  assign luck = lfsr[1:0];

endmodule

// File: rtl/game_sequencer.sv
// Multi-round controller sharing one external stage evaluator across NUM_STAGES rounds.
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT    = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic             cfg_fixed,
  input  logic [6:0]       cfg_hard,
  input  logic [1:0]       cfg_luck,
  game_sequencer_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             final_pass,
  output logic [1:0]       final_bonus,
  output logic [3:0]       fail_stage,
  output logic             timeout_flag
);

  localparam int         TW       = $clog2(TIMEOUT);
  localparam logic [3:0] LAST_IDX = 4'(NUM_STAGES - 1);
  localparam logic [3:0] NO_FAIL  = 4'(NUM_STAGES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [3:0]    idx;
  logic          pass_acc;
  logic [1:0]    bonus_acc;
  logic [TW-1:0] tmo_cnt;
  logic [6:0]    work_r, hard_r;
  logic [1:0]    luck_r, bonus_in_r;
  logic          pass_in_r;
  logic [6:0]    lfsr_hard;
  logic [1:0]    lfsr_luck;
  logic          hs, tmo_hit, stage_failed;

  game_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == IDLE && start),
    .seed  (seed),
    .step  (state == EVAL),
    .hard  (lfsr_hard),
    .luck  (lfsr_luck)
  );

  assign hs           = (state == WAIT_EFF) && bus.eff_valid;
  assign tmo_hit      = (state == WAIT_EFF) && !bus.eff_valid && (tmo_cnt == TMO_LAST);
  assign stage_failed = !bus.stg_pass_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = WAIT_EFF;
      WAIT_EFF: if (hs || tmo_hit) state_nxt = EVAL;
      EVAL: begin
        if (idx == LAST_IDX || (stage_failed && EARLY_EXIT != 0)) state_nxt = DONE;
        else                                                       state_nxt = WAIT_EFF;
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Evaluator operands are latched on entry to EVAL so they stay stable and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      pass_acc     <= 1'b0;
      bonus_acc    <= '0;
      tmo_cnt      <= '0;
      work_r       <= '0;
      hard_r       <= '0;
      luck_r       <= '0;
      pass_in_r    <= 1'b0;
      bonus_in_r   <= '0;
      final_pass   <= 1'b0;
      final_bonus  <= '0;
      fail_stage   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx          <= '0;
            pass_acc     <= 1'b1;
            bonus_acc    <= '0;
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
            fail_stage   <= NO_FAIL;
            final_pass   <= 1'b0;
            final_bonus  <= '0;
          end
        end
        WAIT_EFF: begin
          if (hs || tmo_hit) begin
            tmo_cnt    <= '0;
            work_r     <= hs ? clamp_score(bus.eff_data) : 7'd0;
            hard_r     <= cfg_fixed ? cfg_hard : lfsr_hard;
            luck_r     <= cfg_fixed ? cfg_luck : lfsr_luck;
            pass_in_r  <= pass_acc;
            bonus_in_r <= bonus_acc;
            if (tmo_hit) timeout_flag <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        EVAL: begin
          pass_acc  <= bus.stg_pass_out;
          bonus_acc <= bus.stg_bonus_out;
          if (stage_failed && fail_stage == NO_FAIL) fail_stage <= idx;
          if (state_nxt == WAIT_EFF) idx <= idx + 4'd1;
        end
        DONE: begin
          final_pass  <= pass_acc;
          final_bonus <= bonus_acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.eff_ready    = (state == WAIT_EFF);
  assign bus.stg_work     = work_r;
  assign bus.stg_hard     = hard_r;
  assign bus.stg_luck     = luck_r;
  assign bus.stg_pass_in  = pass_in_r;
  assign bus.stg_bonus_in = bonus_in_r;

  assign busy = (state == WAIT_EFF) || (state == EVAL);
  assign done = (state == DONE);

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer against a round-by-round game model.
module tb_game_sequencer;
  import game_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 8;
  localparam int EE  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       cfg_fixed = 1'b0;
  logic [6:0] cfg_hard = 7'd0;
  logic [1:0] cfg_luck = 2'd0;
  logic       busy, done, final_pass, timeout_flag;
  logic [1:0] final_bonus;
  logic [3:0] fail_stage;

  game_sequencer_if bus();

  game_sequencer #(.NUM_STAGES(N), .TIMEOUT(TMO), .EARLY_EXIT(EE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .cfg_fixed    (cfg_fixed),
    .cfg_hard     (cfg_hard),
    .cfg_luck     (cfg_luck),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .final_pass   (final_pass),
    .final_bonus  (final_bonus),
    .fail_stage   (fail_stage),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  // Environment evaluator attached to the stage bus.
  int ev_total;
  always_comb begin
    ev_total = int'(bus.stg_work) + 4 * int'(bus.stg_bonus_in) + 4 * int'(bus.stg_luck);
    bus.stg_pass_out  = bus.stg_pass_in && (ev_total > int'(bus.stg_hard));
    bus.stg_bonus_out = bus.stg_pass_out ? 2'((ev_total >> 5) & 3) : 2'd0;
  end

  typedef struct {
    int work;
    int hard;
    int luck;
    int pin;
    int bin;
  } ev_t;

  ev_t eval_q[$];
  int  done_cnt = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  total_stages = 0;
  int  eff_a[16];
  bit  pres_a[16];
  int  dly_a[16];

  always @(negedge clk) begin
    if (busy && !bus.eff_ready)
      eval_q.push_back('{int'(bus.stg_work), int'(bus.stg_hard), int'(bus.stg_luck),
                         int'(bus.stg_pass_in), int'(bus.stg_bonus_in)});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  function automatic int hard_of(input int l);
    int v;
    v = l % 128;
    return (v > 100) ? v - 28 : v;
  endfunction

  task automatic drive_game(input bit fixed, input int h, input int lk, input int sd,
                            output int d0);
    int cnt;
    cfg_fixed = fixed;
    cfg_hard  = 7'(h);
    cfg_luck  = 2'(lk);
    seed      = 8'(sd);
    eval_q.delete();
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s <= N; s++) begin
      cnt = 0;
      while (!bus.eff_ready && !done && cnt < 50) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (cnt >= 50) begin
        chk("wait_ready_or_done", 0, 1);
        break;
      end
      if (done) break;
      if (s == N) begin
        chk("stage_overrun", s, N - 1);
        break;
      end
      if (pres_a[s]) begin
        repeat (dly_a[s]) begin @(posedge clk); #1; end
        bus.eff_valid = 1'b1;
        bus.eff_data  = 7'(eff_a[s]);
        @(posedge clk); #1;
        bus.eff_valid = 1'b0;
        bus.eff_data  = 7'($urandom);
      end else begin
        cnt = 0;
        while (bus.eff_ready && cnt < 50) begin
          @(posedge clk); #1;
          cnt++;
        end
        chk("tmo_len", cnt, TMO);
      end
    end
    if (done) begin @(posedge clk); #1; end
  endtask

  // Plays the game from the rules and compares every EVAL cycle and the final report.
  task automatic verify_game(input bit fixed, input int h, input int lk, input int sd,
                             input int d0);
    int l, pass, bonus, fail, tmo, work, eh, el, total, po, bo, run;
    ev_t e;
    l = (sd == 0) ? 1 : sd;
    pass = 1; bonus = 0; fail = N; tmo = 0; run = 0;
    for (int s = 0; s < N; s++) begin
      work = pres_a[s] ? ((eff_a[s] > 100) ? 100 : eff_a[s]) : 0;
      if (!pres_a[s]) tmo = 1;
      eh = fixed ? h : hard_of(l);
      el = fixed ? lk : (l % 4);
      chk("eval_present", eval_q.size() > 0, 1);
      if (eval_q.size() == 0) break;
      e = eval_q.pop_front();
      chk("stg_work", e.work, work);
      chk("stg_hard", e.hard, eh);
      chk("stg_luck", e.luck, el);
      chk("stg_pass_in", e.pin, pass);
      chk("stg_bonus_in", e.bin, bonus);
      chk("hard_le_100", e.hard <= 100, 1);
      total = work + 4 * bonus + 4 * el;
      po = (pass != 0 && total > eh) ? 1 : 0;
      bo = po ? ((total >> 5) & 3) : 0;
      if (po == 0 && fail == N) fail = s;
      pass = po; bonus = bo; l = lfsr_next(l); run++;
      if (pass == 0 && EE != 0) break;
    end
    chk("extra_evals", eval_q.size(), 0);
    chk("final_pass", final_pass, pass);
    chk("final_bonus", final_bonus, bonus);
    chk("fail_stage", fail_stage, fail);
    chk("timeout_flag", timeout_flag, tmo);
    chk("done_pulses", done_cnt - d0, 1);
    total_stages += run;
  endtask

  task automatic plan_all(input int eff, input bit pres);
    for (int s = 0; s < 16; s++) begin
      eff_a[s] = eff; pres_a[s] = pres; dly_a[s] = 0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, n, games, sd, h, lk;
    bit fx;
    bus.eff_valid = 1'b0;
    bus.eff_data  = 7'd0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_final_pass", final_pass, 0);
    chk("rst_final_bonus", final_bonus, 0);
    chk("rst_fail_stage", fail_stage, 0);
    chk("rst_timeout", timeout_flag, 0);
    chk("rst_eff_ready", bus.eff_ready, 0);
    chk("rst_stg_work", bus.stg_work, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency with eff_valid held high, all stages pass.
    plan_all(60, 1'b1);
    cfg_fixed = 1'b1; cfg_hard = 7'd50; cfg_luck = 2'd1; seed = 8'h5A;
    eval_q.delete(); d0 = done_cnt;
    bus.eff_valid = 1'b1; bus.eff_data = 7'd60;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; n = 1;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", n, 2 * N + 1);
    bus.eff_valid = 1'b0;
    @(posedge clk); #1;
    verify_game(1'b1, 50, 1, 'h5A, d0);
    chk("t1_final_bonus", final_bonus, 2);
    chk("t1_fail_stage", fail_stage, 4);

    // Early exit on stage 1.
    plan_all(60, 1'b1); eff_a[1] = 30;
    drive_game(1'b1, 50, 1, 'h33, d0);
    verify_game(1'b1, 50, 1, 'h33, d0);
    chk("t2_fail_stage", fail_stage, 1);

    // No effort at all: stage 0 times out.
    plan_all(0, 1'b0);
    drive_game(1'b1, 50, 1, 'h11, d0);
    verify_game(1'b1, 50, 1, 'h11, d0);
    chk("t3_timeout", timeout_flag, 1);
    chk("t3_fail_stage", fail_stage, 0);

    // Effort above 100 is clamped.
    plan_all(120, 1'b1);
    drive_game(1'b1, 50, 1, 'h22, d0);
    if (eval_q.size() > 0) chk("t4_clamp", eval_q[0].work, 100);
    verify_game(1'b1, 50, 1, 'h22, d0);

    // Zero seed, LFSR-driven hard/luck.
    plan_all(100, 1'b1);
    drive_game(1'b0, 0, 0, 0, d0);
    if (eval_q.size() > 1) begin
      chk("t5_hard0", eval_q[0].hard, 1);
      chk("t5_luck0", eval_q[0].luck, 1);
      chk("t5_hard1", eval_q[1].hard, 2);
      chk("t5_luck1", eval_q[1].luck, 2);
    end
    verify_game(1'b0, 0, 0, 0, d0);

    // Random sweep of at least 1000 stages.
    games = 0;
    while (total_stages < 1000 && games < 2000) begin
      for (int s = 0; s < 16; s++) begin
        eff_a[s]  = $urandom_range(127, 40);
        pres_a[s] = ($urandom_range(7, 0) != 0);
        dly_a[s]  = $urandom_range(3, 0);
      end
      fx = ($urandom_range(3, 0) == 0);
      h  = $urandom_range(100, 0);
      lk = $urandom_range(3, 0);
      sd = $urandom_range(255, 0);
      drive_game(fx, h, lk, sd, d0);
      verify_game(fx, h, lk, sd, d0);
      games++;
    end
    chk("sweep_stages", total_stages >= 1000, 1);

    // Reset while waiting for stage 2 effort.
    plan_all(100, 1'b1);
    cfg_fixed = 1'b1; cfg_hard = 7'd10; cfg_luck = 2'd0;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n = 0;
      while (!bus.eff_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (s < 2) begin
        bus.eff_valid = 1'b1; bus.eff_data = 7'd100;
        @(posedge clk); #1;
        bus.eff_valid = 1'b0;
      end
    end
    chk("t6_in_wait", bus.eff_ready, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_eff_ready", bus.eff_ready, 0);
    chk("t6_fail_stage", fail_stage, 0);
    chk("t6_final_pass", final_pass, 0);
    chk("t6_stg_hard", bus.stg_hard, 0);
    chk("t6_stg_pass_in", bus.stg_pass_in, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_done", done_cnt - d0, 0);
    plan_all(70, 1'b1);
    drive_game(1'b1, 40, 2, 'h77, d0);
    verify_game(1'b1, 40, 2, 'h77, d0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
